// File: rtl/datapath_seq_ctrl_if.sv
// datapath_seq_ctrl_if: decode inputs, memory handshake and datapath enables of the sequencing controller
interface datapath_seq_ctrl_if #(parameter int CNT_W = 16);
  logic start, mem_ready;
  logic [2:0] opcode;
  logic [1:0] ALU_op;
  logic waiting, halted, err;
  logic [1:0] reg_sel, wb_sel;
  logic w_en, en_A, en_B, en_C, en_status, sel_A, sel_B, load_addr, mem_req, mem_we;
  logic [CNT_W-1:0] instr_cnt;
  modport master (
    output start, opcode, ALU_op, mem_ready,
    input waiting, halted, err, reg_sel, wb_sel, w_en, en_A, en_B, en_C, en_status,
    input sel_A, sel_B, load_addr, mem_req, mem_we, instr_cnt
  );
  modport slave (
    input start, opcode, ALU_op, mem_ready,
    output waiting, halted, err, reg_sel, wb_sel, w_en, en_A, en_B, en_C, en_status,
    output sel_A, sel_B, load_addr, mem_req, mem_we, instr_cnt
  );
endinterface

// File: rtl/datapath_seq_ctrl.sv
// datapath_seq_ctrl: multi-cycle simple-RISC controller with ALU latency, LDR/STR memory handshake and timeout
module datapath_seq_ctrl #(
  parameter int ALU_LAT = 1,
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_W = 4,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst_n,
  datapath_seq_ctrl_if.slave bus
);
  typedef enum logic [3:0] {
    IDLE, DECODE, MOVI, GETA, GETB, EXEC, WB, ADDR, LADR, MRD, MWB, RDB, PASS, MWR, HALT, ERR
  } state_t;
  state_t st, ns;
  logic [4:0] ir, ir_n;
  logic [2:0] ex, ex_n;
  logic [TO_W-1:0] to, to_n;
  logic is_cmp, last;
  // outputs are registered from the next state so they are clean Moore outputs of the current state
  always_comb begin
    ir_n = (st == IDLE && bus.start) ? {bus.opcode, bus.ALU_op} : ir;
    ns = st;
    ex_n = ex;
    to_n = to;
    case (st)
      IDLE: ns = bus.start ? DECODE : IDLE;
      DECODE: ns = ir == 5'b11010 ? MOVI : ir == 5'b11000 ? GETB :
                   (ir[4:2] == 3'b101 || ir == 5'b01100 || ir == 5'b10000) ? GETA :
                   ir[4:2] == 3'b111 ? HALT : IDLE;
      MOVI, WB, MWB: ns = IDLE;
      GETA: ns = ir[4:2] == 3'b101 ? GETB : ADDR;
      GETB: begin
        ns = EXEC;
        ex_n = 3'(ALU_LAT - 1);
      end
      EXEC: begin
        ex_n = ex == 3'd0 ? ex : ex - 3'd1;
        ns = ex != 3'd0 ? EXEC : ir == 5'b10101 ? IDLE : WB;
      end
      ADDR: ns = LADR;
      LADR: begin
        ns = ir == 5'b01100 ? MRD : RDB;
        to_n = '0;
      end
      RDB: ns = PASS;
      PASS: begin
        ns = MWR;
        to_n = '0;
      end
      MRD, MWR: begin
        ns = bus.mem_ready ? (st == MRD ? MWB : IDLE) : to == TO_W'(MEM_TIMEOUT - 1) ? ERR : st;
        to_n = to + TO_W'(1);
      end
      default: ns = st;
    endcase
    is_cmp = ir_n == 5'b10101;
    last = ns == EXEC && ex_n == 3'd0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st <= IDLE;
      ir <= '0;
      ex <= '0;
      to <= '0;
      bus.instr_cnt <= '0;
      bus.waiting <= 1'b1;
      {bus.halted, bus.err, bus.reg_sel, bus.wb_sel, bus.w_en, bus.en_A, bus.en_B} <= '0;
      {bus.en_C, bus.en_status, bus.sel_A, bus.sel_B, bus.load_addr, bus.mem_req, bus.mem_we} <= '0;
    end else begin
      st <= ns;
      ir <= ir_n;
      ex <= ex_n;
      to <= to_n;
      if (st == IDLE && bus.start) bus.instr_cnt <= bus.instr_cnt + CNT_W'(1);
      bus.waiting <= ns == IDLE;
      bus.halted <= ns == HALT;
      bus.err <= ns == ERR;
      bus.reg_sel <= (ns == MOVI || ns == GETA) ? 2'b10 : (ns == WB || ns == MWB || ns == RDB) ? 2'b01 : 2'b00;
      bus.wb_sel <= ns == MOVI ? 2'b10 : ns == MWB ? 2'b11 : 2'b00;
      bus.w_en <= ns == MOVI || ns == WB || ns == MWB;
      bus.en_A <= ns == GETA;
      bus.en_B <= ns == GETB || ns == RDB;
      bus.en_C <= (last && !is_cmp) || ns == ADDR || ns == PASS;
      bus.en_status <= last && is_cmp;
      bus.sel_A <= (ns == EXEC && (ir_n == 5'b11000 || ir_n == 5'b10111)) || ns == PASS;
      bus.sel_B <= ns == ADDR;
      bus.load_addr <= ns == LADR;
      bus.mem_req <= ns == MRD || ns == MWR;
      bus.mem_we <= ns == MWR;
    end
  end
endmodule
